tqvp_vga_capture: RTL



---
 rtl/tqvp_vga_capture.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_vga_capture.sv
// rtl/tqvp_vga_capture.sv - 1-bit grid capture of a VGA-style input for TinyQV; optional VGA_CAP_MEASURE_EN adds line/frame timing counters
module tqvp_vga_capture #(
    parameter int PIXEL_COUNT     = 320,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam logic       SYNC_INV = (SYNC_ACTIVE_LOW != 0);
    localparam logic [9:0] PIX_LIM  = 10'(PIXEL_COUNT);
    localparam logic [4:0] WORDS    = 5'(PIXEL_COUNT / 32);

    typedef enum logic [1:0] {IDLE, WAIT_VS, V_SKIP, ACTIVE} state_t;

    // Sync decode: hs/vs read 1 while the sync pulse is asserted
    logic       hs, vs, hs_prev, vs_prev;
    logic       line_start, frame_start;
    logic [5:0] pixel;

    assign hs          = ui_in[7] ^ SYNC_INV;
    assign vs          = ui_in[3] ^ SYNC_INV;
    assign pixel       = {ui_in[6:4], ui_in[2:0]};
    assign line_start  = hs_prev & ~hs;
    assign frame_start = vs_prev & ~vs;

    // Bus decode
    logic       wr_any, wr_32, rd_any;
    logic [3:0] reg_sel;
    logic       ctrl_wr, arm, abort, ack;

    assign wr_any  = (data_write_n != 2'b11);
    assign wr_32   = (data_write_n == 2'b10);
    assign rd_any  = (data_read_n != 2'b11);
    assign reg_sel = address[5:2];
    assign ctrl_wr = wr_any && (reg_sel == 4'd12);
    assign arm     = ctrl_wr & data_in[0];
    assign abort   = ctrl_wr & data_in[1];
    assign ack     = ctrl_wr & data_in[2];

    // Configuration registers
    logic [10:0] h_start;
    logic [6:0]  h_step;
    logic [9:0]  v_start;
    logic [6:0]  v_step;
    logic [5:0]  cols, rows, mask;

    // Capture state
    state_t      state;
    logic        done_flag, short_flag;
    logic [8:0]  index;
    logic [9:0]  line_cnt;
    logic [5:0]  row, col;
    logic [6:0]  vphase;
    logic [10:0] hcount;
    logic [11:0] next_sample;
    logic [PIXEL_COUNT-1:0] buffer;

    // Zero steps/columns behave as one so the capture always makes progress
    logic [6:0]  h_step_eff, v_step_eff;
    logic [5:0]  cols_eff;
    logic        vphase_last, row_done, trunc, sample_fire, sample_bit;
    logic [6:0]  row_next;
    logic [12:0] jump_prod;
    logic [8:0]  jump_index, index_inc;
    logic [10:0] hcount_inc;

    assign h_step_eff  = (h_step == 7'd0) ? 7'd1 : h_step;
    assign v_step_eff  = (v_step == 7'd0) ? 7'd1 : v_step;
    assign cols_eff    = (cols == 6'd0) ? 6'd1 : cols;
    assign vphase_last = (vphase >= v_step_eff - 7'd1);
    assign row_next    = {1'b0, row} + 7'd1;
    assign row_done    = vphase_last && (row_next >= {1'b0, rows});
    assign trunc       = (vphase == 7'd0) && (col < cols_eff);
    assign jump_prod   = {6'd0, row_next} * {7'd0, cols_eff};
    assign jump_index  = (jump_prod > 13'd511) ? 9'd511 : jump_prod[8:0];
    assign index_inc   = (index == 9'd511) ? index : index + 9'd1;
    assign hcount_inc  = (hcount == 11'h7FF) ? hcount : hcount + 11'd1;
    assign sample_bit  = |(pixel & mask);
    assign sample_fire = (state == ACTIVE) && !line_start && !frame_start && !arm && !abort
                         && (vphase == 7'd0) && (col < cols_eff)
                         && ({1'b0, hcount} == next_sample);

    // Previous sync levels for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            hs_prev <= hs;
            vs_prev <= vs;
        end
    end

    // Geometry/grid registers, updated only by full-word writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_start <= 11'd186;
            h_step  <= 7'd52;
            v_start <= 10'd53;
            v_step  <= 7'd48;
            cols    <= 6'd20;
            rows    <= 6'd16;
            mask    <= 6'h3F;
        end else if (wr_32) begin
            case (reg_sel)
                4'd13: begin
                    h_start <= data_in[10:0];
                    h_step  <= data_in[22:16];
                end
                4'd14: begin
                    v_start <= data_in[9:0];
                    v_step  <= data_in[22:16];
                end
                4'd15: begin
                    cols <= data_in[5:0];
                    rows <= data_in[13:8];
                    mask <= data_in[21:16];
                end
                default: ;
            endcase
        end
    end

    // Capture FSM; CPU control writes are applied last so they override capture events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            done_flag   <= 1'b0;
            short_flag  <= 1'b0;
            index       <= 9'd0;
            line_cnt    <= 10'd0;
            row         <= 6'd0;
            col         <= 6'd0;
            vphase      <= 7'd0;
            hcount      <= 11'd0;
            next_sample <= 12'd0;
        end else begin
            // hcount reads 0 on the clock after a line-start edge
            hcount <= line_start ? 11'd0 : hcount_inc;
            case (state)
                IDLE: ;
                WAIT_VS: begin
                    if (frame_start) begin
                        state    <= V_SKIP;
                        line_cnt <= 10'd0;
                    end
                end
                V_SKIP: begin
                    if (frame_start) begin
                        state      <= IDLE;
                        done_flag  <= 1'b1;
                        short_flag <= 1'b1;
                    end else if (line_start) begin
                        line_cnt <= line_cnt + 10'd1;
                        if (line_cnt == v_start) begin
                            if (rows == 6'd0) begin
                                state     <= IDLE;
                                done_flag <= 1'b1;
                            end else begin
                                state       <= ACTIVE;
                                row         <= 6'd0;
                                vphase      <= 7'd0;
                                col         <= 6'd0;
                                next_sample <= {1'b0, h_start};
                            end
                        end
                    end
                end
                ACTIVE: begin
                    if (frame_start) begin
                        state      <= IDLE;
                        done_flag  <= 1'b1;
                        short_flag <= 1'b1;
                    end else if (line_start) begin
                        col         <= 6'd0;
                        next_sample <= {1'b0, h_start};
                        // A sample line that ended early skips to the next row's first bit
                        if (trunc)
                            index <= jump_index;
                        vphase <= vphase_last ? 7'd0 : vphase + 7'd1;
                        if (vphase_last)
                            row <= row_next[5:0];
                        if (row_done) begin
                            state     <= IDLE;
                            done_flag <= 1'b1;
                        end
                    end else if (sample_fire) begin
                        index       <= index_inc;
                        col         <= col + 6'd1;
                        next_sample <= next_sample + {5'd0, h_step_eff};
                    end
                end
                default: state <= IDLE;
            endcase
            if (ack)
                done_flag <= 1'b0;
            if (abort)
                state <= IDLE;
            if (arm) begin
                state      <= WAIT_VS;
                done_flag  <= 1'b0;
                short_flag <= 1'b0;
                index      <= 9'd0;
            end
        end
    end

    // Capture buffer write; samples past the buffer end are dropped
    always_ff @(posedge clk) begin
        if (sample_fire && ({1'b0, index} < PIX_LIM))
            buffer[index] <= sample_bit;
    end

    logic [31:0] measure_word;

`ifdef VGA_CAP_MEASURE_EN
    logic [15:0] period_cnt, period_latched;
    logic [9:0]  frame_lines, frame_lines_latched;

    // Line period and lines-per-frame counters, latched on each line/frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt          <= 16'd0;
            period_latched      <= 16'd0;
            frame_lines         <= 10'd0;
            frame_lines_latched <= 10'd0;
        end else begin
            if (line_start) begin
                period_latched <= period_cnt;
                period_cnt     <= 16'd1;
            end else if (period_cnt != 16'hFFFF) begin
                period_cnt <= period_cnt + 16'd1;
            end
            if (frame_start) begin
                frame_lines_latched <= frame_lines;
                frame_lines         <= line_start ? 10'd1 : 10'd0;
            end else if (line_start) begin
                frame_lines <= frame_lines + 10'd1;
            end
        end
    end

    assign measure_word = {6'd0, frame_lines_latched, period_latched};
`else
    assign measure_word = 32'd0;
`endif

    // Combinational register read mux
    logic [31:0] rdata;
    always_comb begin
        rdata = 32'd0;
        case (reg_sel)
            4'd11: rdata = measure_word;
            4'd12: rdata = {7'd0, index, 13'd0, short_flag, done_flag, (state != IDLE)};
            4'd13: rdata = {9'd0, h_step, 5'd0, h_start};
            4'd14: rdata = {9'd0, v_step, 6'd0, v_start};
            4'd15: rdata = {10'd0, mask, 2'd0, rows, 2'd0, cols};
            default: begin
                if ({1'b0, reg_sel} < WORDS)
                    rdata = buffer[{reg_sel, 5'd0} +: 32];
            end
        endcase
    end

    assign data_out       = rd_any ? rdata : 32'd0;
    assign data_ready     = 1'b1;
    assign uo_out         = 8'd0;
    assign user_interrupt = done_flag;

    logic unused_bits;
    assign unused_bits = &{1'b0, address[1:0], data_in[31:23], data_in[15:14]};

endmodule
